idex_stage: RTL and testbench
=============================

# idex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage CPU. It captures decoded control, operands, immediate and register addresses from ID, and presents them to EX and to the forwarding logic. It stalls PC and IF/ID on a load-use dependency and inserts a bubble on stall or branch flush. It also counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- DW, 32, datapath width
- CW, 16, bubble-counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- hold_i  in  1  global freeze (e.g. memory wait); all state keeps its value
- flush_i  in  1  branch taken; the instruction in ID is squashed
- id_valid_i  in  1  ID holds a real instruction
- id_ctrl_i  in  9  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst, Branch}
- id_rs_data_i, id_rt_data_i  in  DW  register-file read data
- id_imm_i  in  DW  sign-extended immediate
- id_rs_addr_i, id_rt_addr_i, id_rd_addr_i  in  5  register addresses
- id_uses_rt_i  in  1  instruction reads rt as a source operand
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_ctrl_o  out  9  registered control
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DW  registered operands
- ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o  out  5  registered addresses; feed forwarding unit and write-address mux
- stall_o  out  1  combinational; deasserts PC write and IF/ID write
- bubble_cnt_o  out  CW  saturating count of inserted bubbles

## Operation
- Load-use hazard: hz = ex_valid_o & ex_ctrl_o.MemRead & (ex_rt_addr_o != 0) & id_valid_i & ((ex_rt_addr_o == id_rs_addr_i) | (id_uses_rt_i & ex_rt_addr_o == id_rt_addr_i)).
- stall_o = hz & ~flush_i. A flush discards the dependent instruction, so no stall is needed.
- Per-edge update, in priority order:
  - rst_i == 0: ex_valid_o = 0, ex_ctrl_o = 0, all data and address outputs = 0, bubble_cnt_o = 0.
  - hold_i: all registers unchanged; bubble_cnt_o unchanged.
  - flush_i or hz: bubble is inserted. ex_valid_o = 0, ex_ctrl_o = 0. Data and address fields load from ID, which is harmless because control is 0. bubble_cnt_o increments by 1.
  - Otherwise: load all fields from ID; ex_valid_o = id_valid_i. If id_valid_i == 0, ex_ctrl_o = 0.
- A bubble always carries RegWrite = MemRead = MemWrite = 0, so the forwarding unit and memory never act on it.
- Simultaneous flush_i and hz produce exactly one bubble and one count increment.
- bubble_cnt_o saturates at 2^CW−1; it does not wrap.
- stall_o is evaluated whenever its inputs are valid, including during hold_i; upstream must OR it with hold_i.

## Timing
- Latency ID→EX: 1 cycle.
- Load-use sequence:
  - Cycle n: lw in ID/EX, dependent instruction in ID, stall_o = 1.
  - Edge n+1: bubble enters ID/EX; PC and IF/ID hold.
  - Cycle n+1: ID/EX MemRead = 0, so stall_o = 0.
  - Edge n+2: dependent instruction enters EX, with lw in MEM/WB for forwarding.
- Exactly one stall cycle per load-use hazard.
- stall_o has no registered delay: it is valid in the same cycle as the ID inputs.
- Reset mid-stall: the bubble is discarded, outputs go to 0 on that edge, and stall_o = 0 from the next cycle.
- Hold mid-stall: stall_o stays 1 for the whole hold. The bubble is inserted on the first non-hold edge.
- Reset values: all outputs 0; stall_o = 0 after reset because ex_valid_o = 0.

## Test plan
- Reset: drive rst_i = 0 for 2 edges with nonzero ID inputs -> all ex_* = 0, bubble_cnt_o = 0, stall_o = 0.
- Pass-through: ID add $3,$1,$2 (ctrl RegWrite|RegDst, rs = 1, rt = 2, rd = 3, data 5/7) -> next cycle ex_rs_data_o = 5, ex_rt_data_o = 7, ex_rd_addr_o = 3, ex_valid_o = 1, stall_o = 0.
- Load-use: lw $2,0($1), then add $4,$2,$5 -> stall_o = 1 for one cycle. The next cycle shows ex_ctrl_o = 0 and bubble_cnt_o = 1. The cycle after shows ex_rs_addr_o = 2.
- Dependency boundaries:
  - lw $0 followed by a reader of $0 -> no stall.
  - lw $2 followed by an instruction with rt = 2 and id_uses_rt_i = 0 -> no stall.
- Flush during hazard: flush_i = 1 while hz = 1 -> stall_o = 0; one bubble; bubble_cnt_o increments by 1 only.
- Hold and saturation:
  - hold_i = 1 for 3 cycles during a stall -> outputs frozen, stall_o = 1 throughout.
  - Force 2^CW bubbles -> bubble_cnt_o = 0xFFFF and stays there.

Source files
------------

// File: rtl/idex_stage.sv
// ID/EX pipeline register for the five-stage CPU, with load-use hazard detection,
// bubble insertion on stall or branch flush, and a saturating bubble counter.
module idex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [8:0]    id_ctrl_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [4:0]    id_rs_addr_i,
    input  logic [4:0]    id_rt_addr_i,
    input  logic [4:0]    id_rd_addr_i,
    input  logic          id_uses_rt_i,
    output logic          ex_valid_o,
    output logic [8:0]    ex_ctrl_o,
    output logic [DW-1:0] ex_rs_data_o,
    output logic [DW-1:0] ex_rt_data_o,
    output logic [DW-1:0] ex_imm_o,
    output logic [4:0]    ex_rs_addr_o,
    output logic [4:0]    ex_rt_addr_o,
    output logic [4:0]    ex_rd_addr_o,
    output logic          stall_o,
    output logic [CW-1:0] bubble_cnt_o
);

    // Control word layout: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst, Branch}
    localparam int MEMREAD_BIT = 6;

    logic          r_vld_p1;
    logic [8:0]    r_ctrl_p1;
    logic [DW-1:0] r_rs_data_p1;
    logic [DW-1:0] r_rt_data_p1;
    logic [DW-1:0] r_imm_p1;
    logic [4:0]    r_rs_addr_p1;
    logic [4:0]    r_rt_addr_p1;
    logic [4:0]    r_rd_addr_p1;
    logic [CW-1:0] r_bubble_cnt;

    logic          w_rs_match;
    logic          w_rt_match;
    logic          w_hz;
    logic          w_bubble;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v)
            return v;
        return v + CW'(1);
    endfunction

    // A load into $0 never produces a value, so it cannot create a dependency.
    assign w_rs_match = (r_rt_addr_p1 == id_rs_addr_i);
    assign w_rt_match = id_uses_rt_i && (r_rt_addr_p1 == id_rt_addr_i);
    assign w_hz       = r_vld_p1 && r_ctrl_p1[MEMREAD_BIT] && (r_rt_addr_p1 != 5'd0) &&
                        id_valid_i && (w_rs_match || w_rt_match);

    // The flushed instruction is discarded anyway, so no stall is required.
    assign stall_o  = w_hz && !flush_i;
    assign w_bubble = flush_i || w_hz;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_vld_p1     <= 1'b0;
            r_ctrl_p1    <= '0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
            r_rs_addr_p1 <= '0;
            r_rt_addr_p1 <= '0;
            r_rd_addr_p1 <= '0;
            r_bubble_cnt <= '0;
        end else if (!hold_i) begin
            r_rs_data_p1 <= id_rs_data_i;
            r_rt_data_p1 <= id_rt_data_i;
            r_imm_p1     <= id_imm_i;
            r_rs_addr_p1 <= id_rs_addr_i;
            r_rt_addr_p1 <= id_rt_addr_i;
            r_rd_addr_p1 <= id_rd_addr_i;
            if (w_bubble) begin
                r_vld_p1     <= 1'b0;
                r_ctrl_p1    <= '0;
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_vld_p1  <= id_valid_i;
                r_ctrl_p1 <= id_valid_i ? id_ctrl_i : 9'd0;
            end
        end
    end

    assign ex_valid_o   = r_vld_p1;
    assign ex_ctrl_o    = r_ctrl_p1;
    assign ex_rs_data_o = r_rs_data_p1;
    assign ex_rt_data_o = r_rt_data_p1;
    assign ex_imm_o     = r_imm_p1;
    assign ex_rs_addr_o = r_rs_addr_p1;
    assign ex_rt_addr_o = r_rt_addr_p1;
    assign ex_rd_addr_o = r_rd_addr_p1;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_idex_stage.sv
// Directed scoreboard bench for idex_stage: expected register contents are queued on
// each drive and checked one edge later; stall_o is checked against hand-given values.
module tb_idex_stage;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i, hold_i, flush_i, id_valid_i, id_uses_rt_i;
    logic [8:0]    id_ctrl_i;
    logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]    id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic          ex_valid_o, stall_o;
    logic [8:0]    ex_ctrl_o;
    logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [4:0]    ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
    logic [CW-1:0] bubble_cnt_o;

    idex_stage #(.DW(DW), .CW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_uses_rt_i(id_uses_rt_i),
        .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
        .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [8:0] C_ADD = 9'h102;  // RegWrite | RegDst
    localparam logic [8:0] C_LW  = 9'h1D0;  // RegWrite | MemtoReg | MemRead | ALUSrc
    localparam logic [8:0] C_ALL = 9'h1FF;

    typedef struct {
        logic          v;
        logic [8:0]    c;
        logic [DW-1:0] rsd, rtd, imm;
        logic [4:0]    rsa, rta, rda;
        logic [CW-1:0] cnt;
    } st_t;

    st_t q[$];
    st_t m;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the register contents after the next edge; bubble decision comes from exp_hz.
    function automatic st_t next_state(input st_t cur, input logic rst, input logic hold,
                                       input logic flush, input logic exp_hz);
        st_t n = cur;
        if (!rst) begin
            n.v = 1'b0; n.c = '0; n.rsd = '0; n.rtd = '0; n.imm = '0;
            n.rsa = '0; n.rta = '0; n.rda = '0; n.cnt = '0;
        end else if (!hold) begin
            n.rsd = id_rs_data_i; n.rtd = id_rt_data_i; n.imm = id_imm_i;
            n.rsa = id_rs_addr_i; n.rta = id_rt_addr_i; n.rda = id_rd_addr_i;
            if (flush || exp_hz) begin
                n.v = 1'b0; n.c = '0;
                n.cnt = (cur.cnt == '1) ? cur.cnt : cur.cnt + 1'b1;
            end else begin
                n.v = id_valid_i;
                n.c = id_valid_i ? id_ctrl_i : 9'd0;
            end
        end
        return n;
    endfunction

    task automatic compare_out(input string tag);
        st_t e;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_valid"},  64'(ex_valid_o),   64'(e.v));
        chk({tag, "_ctrl"},   64'(ex_ctrl_o),    64'(e.c));
        chk({tag, "_rsdata"}, 64'(ex_rs_data_o), 64'(e.rsd));
        chk({tag, "_rtdata"}, 64'(ex_rt_data_o), 64'(e.rtd));
        chk({tag, "_imm"},    64'(ex_imm_o),     64'(e.imm));
        chk({tag, "_rsaddr"}, 64'(ex_rs_addr_o), 64'(e.rsa));
        chk({tag, "_rtaddr"}, 64'(ex_rt_addr_o), 64'(e.rta));
        chk({tag, "_rdaddr"}, 64'(ex_rd_addr_o), 64'(e.rda));
        chk({tag, "_bubcnt"}, 64'(bubble_cnt_o), 64'(e.cnt));
    endtask

    // Called just after a rising edge: applies ID inputs, checks stall_o, clocks once, checks EX.
    task automatic drive(input string tag, input logic rst, input logic hold, input logic flush,
                         input logic valid, input logic [8:0] ctrl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic uses_rt, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                         input logic [DW-1:0] imm, input bit chk_stall, input logic exp_stall,
                         input logic exp_hz);
        rst_i = rst; hold_i = hold; flush_i = flush; id_valid_i = valid; id_ctrl_i = ctrl;
        id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd; id_uses_rt_i = uses_rt;
        id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
        #1;
        if (chk_stall)
            chk({tag, "_stall"}, 64'(stall_o), 64'(exp_stall));
        m = next_state(m, rst, hold, flush, exp_hz);
        q.push_back(m);
        @(posedge clk_i);
        #1;
        compare_out(tag);
    endtask

    initial begin
        m = '{v: 1'b0, c: '0, rsd: '0, rtd: '0, imm: '0, rsa: '0, rta: '0, rda: '0, cnt: '0};
        @(posedge clk_i);
        #1;
        // Reset with busy ID inputs
        drive("rst0", 0, 0, 0, 1, C_ALL, 5'd9, 5'd9, 5'd9, 1, 32'hDEAD, 32'hBEEF, 32'h1234, 0, 0, 0);
        drive("rst1", 0, 0, 0, 1, C_ALL, 5'd9, 5'd9, 5'd9, 1, 32'hDEAD, 32'hBEEF, 32'h1234, 1, 0, 0);
        // add $3,$1,$2 pass-through
        drive("add",  1, 0, 0, 1, C_ADD, 5'd1, 5'd2, 5'd3, 1, 32'd5, 32'd7, 32'd0, 1, 0, 0);
        // lw $2,0($1) then dependent add $4,$2,$5
        drive("lw2",  1, 0, 0, 1, C_LW,  5'd1, 5'd2, 5'd0, 0, 32'd5, 32'd0, 32'd0, 1, 0, 0);
        drive("luse", 1, 0, 0, 1, C_ADD, 5'd2, 5'd5, 5'd4, 1, 32'd11, 32'd12, 32'd0, 1, 1, 1);
        drive("lrel", 1, 0, 0, 1, C_ADD, 5'd2, 5'd5, 5'd4, 1, 32'd11, 32'd12, 32'd0, 1, 0, 0);
        chk("luse_rsaddr_after", 64'(ex_rs_addr_o), 64'd2);
        chk("luse_cnt_one", 64'(bubble_cnt_o), 64'd1);
        // lw $0 followed by a reader of $0
        drive("lw0",  1, 0, 0, 1, C_LW,  5'd1, 5'd0, 5'd0, 0, 32'd1, 32'd0, 32'd4, 1, 0, 0);
        drive("rd0",  1, 0, 0, 1, C_ADD, 5'd0, 5'd0, 5'd6, 1, 32'd0, 32'd0, 32'd0, 1, 0, 0);
        // lw $2 followed by rt=2 with uses_rt=0
        drive("lw2b", 1, 0, 0, 1, C_LW,  5'd3, 5'd2, 5'd0, 0, 32'd8, 32'd0, 32'd8, 1, 0, 0);
        drive("nort", 1, 0, 0, 1, 9'h110, 5'd6, 5'd2, 5'd0, 0, 32'd3, 32'd4, 32'h10, 1, 0, 0);
        // Flush coinciding with a hazard
        drive("lw2c", 1, 0, 0, 1, C_LW,  5'd3, 5'd2, 5'd0, 0, 32'd8, 32'd0, 32'd8, 1, 0, 0);
        drive("flhz", 1, 0, 1, 1, C_ADD, 5'd2, 5'd1, 5'd9, 1, 32'd2, 32'd3, 32'd0, 1, 0, 1);
        chk("flhz_cnt_two", 64'(bubble_cnt_o), 64'd2);
        // Hold for three cycles during a stall
        drive("lw7",  1, 0, 0, 1, C_LW,  5'd1, 5'd7, 5'd0, 0, 32'd9, 32'd0, 32'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            drive("hold", 1, 1, 0, 1, C_ADD, 5'd7, 5'd1, 5'd10, 1, 32'd70, 32'd71, 32'd0, 1, 1, 1);
        drive("hrel", 1, 0, 0, 1, C_ADD, 5'd7, 5'd1, 5'd10, 1, 32'd70, 32'd71, 32'd0, 1, 1, 1);
        drive("hfin", 1, 0, 0, 1, C_ADD, 5'd7, 5'd1, 5'd10, 1, 32'd70, 32'd71, 32'd0, 1, 0, 0);
        chk("hold_cnt_three", 64'(bubble_cnt_o), 64'd3);
        // Reset in the middle of a stall
        drive("lw8",  1, 0, 0, 1, C_LW,  5'd1, 5'd8, 5'd0, 0, 32'd1, 32'd0, 32'd0, 1, 0, 0);
        drive("rstz", 0, 0, 0, 1, C_ADD, 5'd8, 5'd2, 5'd11, 1, 32'd80, 32'd81, 32'd0, 1, 1, 1);
        drive("rstr", 1, 0, 0, 1, C_ADD, 5'd8, 5'd2, 5'd11, 1, 32'd80, 32'd81, 32'd0, 1, 0, 0);
        // Invalid instruction must not carry control into EX
        drive("inval", 1, 0, 0, 0, C_ALL, 5'd4, 5'd5, 5'd6, 1, 32'd40, 32'd50, 32'd60, 1, 0, 0);
        // Saturation: more than 2^CW consecutive flush bubbles
        flush_i = 1'b1;
        repeat ((1 << CW) + 4) @(posedge clk_i);
        #1;
        chk("sat_reach", 64'(bubble_cnt_o), 64'hFFFF);
        m.v = 1'b0; m.c = '0; m.cnt = '1;
        m.rsd = id_rs_data_i; m.rtd = id_rt_data_i; m.imm = id_imm_i;
        m.rsa = id_rs_addr_i; m.rta = id_rt_addr_i; m.rda = id_rd_addr_i;
        drive("sat_hold", 1, 0, 1, 1, C_ADD, 5'd1, 5'd2, 5'd3, 1, 32'd1, 32'd2, 32'd3, 1, 0, 0);
        drive("sat_pass", 1, 0, 0, 1, C_ADD, 5'd1, 5'd2, 5'd3, 1, 32'd1, 32'd2, 32'd3, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
